mem_dma: RTL and testbench
==========================

Name: mem_dma

Overview:
- Word-copy DMA engine in front of the mem block's read port 1 and its write port.
- The CPU programs source, destination and length through a 4-register config interface.
- The engine streams words from source to destination and shares both mem ports with the CPU. The CPU always has priority.
- Typical uses are bulk loads of tile_map and frame_buffer from RAM and block copies within RAM.

Parameters:
- RD_LAT, 2, number of clk_en cycles from raddr1 presented to rdata1 valid at mem.
- FIFO_DEPTH, 4, entries in the read-data buffer; must be a power of two and ≥ RD_LAT+1.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- clk_en  in  1  global clock enable; all state advances only when high
- cfg_wen  in  1  config register write strobe
- cfg_addr  in  2  config register select: 0 SRC, 1 DST, 2 LEN, 3 CTRL
- cfg_wdata  in  32  config write data
- cfg_rdata  out  32  combinational readback of the register at cfg_addr
- cpu_raddr1  in  18  CPU read address for mem port 1
- cpu_rreq1  in  1  CPU needs port 1 this cycle
- cpu_wen  in  4  CPU byte write enables
- cpu_waddr  in  18  CPU write address
- cpu_wdata  in  32  CPU write data
- mem_raddr1  out  18  to mem raddr1
- mem_rdata1  in  32  from mem rdata1
- mem_wen  out  4  to mem wen
- mem_waddr  out  18  to mem waddr
- mem_wdata  out  32  to mem wdata
- busy  out  1  transfer in progress
- irq  out  1  one-clk_en-cycle pulse when a transfer completes or is aborted

Behaviour:

Reset:
- All registers clear. State is IDLE.
- busy=0, irq=0, done=0, FIFO empty, in-flight pipe cleared.

Config registers:
- SRC and DST are 18 bits. Bits [1:0] are forced to 0 on write.
- LEN is 16 bits, counted in words.
- Writes to SRC, DST or LEN while busy are ignored.
- CTRL write: bit0 starts a transfer (ignored if busy); bit1 aborts.
- CTRL read: bit0 = busy, bit1 = done (sticky; cleared by start).
- Unused readback bits are 0.

Port muxing:
- Read: when cpu_rreq1=1 or the engine is not issuing, mem_raddr1 = cpu_raddr1; otherwise mem_raddr1 = the engine's read pointer.
- Write: if cpu_wen != 0, mem_* = cpu_*. Otherwise, if the engine is writing, mem_wen = 4'hF with the engine's address and data. Otherwise mem_wen = 0.

States:
- IDLE
  - On start with LEN=0: done=1, irq pulse, stay in IDLE.
  - On start with LEN>0: latch rd_ptr=SRC, wr_ptr=DST, rd_left=wr_left=LEN; go to RUN.
- RUN
  - Issue a read in any clk_en cycle where all of the following hold: cpu_rreq1=0, rd_left>0, and FIFO occupancy plus in-flight count < FIFO_DEPTH.
  - On issue: rd_ptr += 4 (modulo 2^18) and rd_left -= 1.
  - The in-flight pipe is a RD_LAT-deep shift register of valid bits. When a valid bit exits the pipe, capture mem_rdata1 into the FIFO.
  - Write in any clk_en cycle where the FIFO is non-empty and cpu_wen == 0.
  - On write: pop the FIFO head to mem_wdata, wr_ptr += 4 (modulo 2^18), wr_left -= 1.
  - When rd_left reaches 0, go to DRAIN.
- DRAIN
  - Writes only.
  - When wr_left reaches 0: done=1, irq pulse, go to IDLE.
- Abort (from any state)
  - Return to IDLE and flush the FIFO and pipe.
  - Set done=1 and pulse irq.
  - Data from in-flight reads is discarded.

Rules and boundaries:
- busy = 1 exactly in RUN and DRAIN.
- An FIFO push and pop in the same cycle is legal; occupancy is then unchanged.
- The credit rule guarantees the FIFO never overflows, so no push is ever dropped.
- When clk_en=0: no issue, no write, mem_wen=0, and the pipe does not shift.
- Overlapping source and destination regions get no special handling. The copy is strictly ascending.
- Addresses wrap from 0x3FFFC to 0x00000.
- Reset asserted mid-transfer returns to IDLE; no irq is produced.

Test Plan:
1. SRC=0x100, DST=0x2A000, LEN=4, RAM 0x100..0x10C = A0..A3, CPU idle -> tile_map words 0..3 = A0..A3; irq pulses once; done=1; busy=0; 4 reads and 4 writes total.
2. As test 1 with cpu_rreq1 high for 5 cycles mid-run -> no engine read issued while it is high; final data intact; completion delayed by exactly 5 cycles.
3. LEN=8 with cpu_wen=4'hF to 0x40 every other cycle -> CPU writes land; all 8 DMA words are correct; the FIFO never exceeds FIFO_DEPTH (assertion).
4. Start with LEN=0 -> irq on the next clk_en cycle; done=1; busy never asserts; no mem_wen from the engine.
5. LEN=16 with abort after the 3rd write -> exactly 3 destination words written; busy=0; irq=1 once; the 4th destination word is unchanged.
6. SRC=0x3FFF8, LEN=3 -> reads at 0x3FFF8, 0x3FFFC, 0x00000; writing SRC/DST/LEN while busy leaves the readback unchanged.

Source files
------------

// File: rtl/mem_dma.sv
// mem_dma: word-copy DMA engine sharing mem read port 1 and the write port with the CPU.
// CPU accesses always win; read data is buffered in a small FIFO between read and write streams.
module mem_dma #(
  parameter int RD_LAT     = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clk_en,
  input  logic        cfg_wen,
  input  logic [1:0]  cfg_addr,
  input  logic [31:0] cfg_wdata,
  output logic [31:0] cfg_rdata,
  input  logic [17:0] cpu_raddr1,
  input  logic        cpu_rreq1,
  input  logic [3:0]  cpu_wen,
  input  logic [17:0] cpu_waddr,
  input  logic [31:0] cpu_wdata,
  output logic [17:0] mem_raddr1,
  input  logic [31:0] mem_rdata1,
  output logic [3:0]  mem_wen,
  output logic [17:0] mem_waddr,
  output logic [31:0] mem_wdata,
  output logic        busy,
  output logic        irq
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW:0] DEPTH_C = (CW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;
  state_t state, state_nxt;

  logic [17:0]       src_q, dst_q, rd_ptr, wr_ptr;
  logic [15:0]       len_q, rd_left, wr_left;
  logic              done_q, irq_q;
  logic [RD_LAT-1:0] pipe, pipe_nxt;
  logic [31:0]       fifo_mem [FIFO_DEPTH];
  logic [AW-1:0]     fifo_rd_idx, fifo_wr_idx;
  logic [CW-1:0]     fifo_cnt, inflight;
  logic              ctrl_wr, abort, start, launch, finish;
  logic              credit_ok, issue, eng_wr, push;
  logic              unused_wdata;

  assign unused_wdata = ^cfg_wdata[31:18];
  assign busy = (state != S_IDLE);
  assign irq  = irq_q;

  always_comb begin
    ctrl_wr = clk_en && cfg_wen && (cfg_addr == 2'd3);
    abort   = ctrl_wr && cfg_wdata[1];
    start   = ctrl_wr && cfg_wdata[0] && !busy && !abort;
    inflight = '0;
    for (int unsigned i = 0; i < RD_LAT; i++) inflight = inflight + CW'(pipe[i]);
    // Reads in flight already own a FIFO slot, so the FIFO can never overflow.
    credit_ok = ({1'b0, fifo_cnt} + {1'b0, inflight}) < DEPTH_C;
    issue  = clk_en && (state == S_RUN) && !cpu_rreq1 && (rd_left != '0) && credit_ok && !abort;
    eng_wr = clk_en && busy && (fifo_cnt != '0) && (cpu_wen == '0) && !abort;
    push   = clk_en && pipe[RD_LAT-1] && !abort;
    pipe_nxt = '0;
    pipe_nxt[0] = issue;
    for (int unsigned i = 1; i < RD_LAT; i++) pipe_nxt[i] = pipe[i-1];
  end

  always_comb begin
    state_nxt = state;
    launch    = 1'b0;
    finish    = 1'b0;
    if (abort) begin
      state_nxt = S_IDLE;
      finish    = 1'b1;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (start) begin
            if (len_q == '0) begin
              finish = 1'b1;
            end else begin
              launch    = 1'b1;
              state_nxt = S_RUN;
            end
          end
        end
        S_RUN: begin
          if (rd_left == '0) state_nxt = S_DRAIN;
        end
        S_DRAIN: begin
          if (wr_left == '0) begin
            state_nxt = S_IDLE;
            finish    = 1'b1;
          end
        end
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else if (clk_en) state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      src_q  <= '0;
      dst_q  <= '0;
      len_q  <= '0;
      done_q <= 1'b0;
      irq_q  <= 1'b0;
    end else if (clk_en) begin
      irq_q <= finish;
      if (finish) done_q <= 1'b1;
      else if (start) done_q <= 1'b0;
      if (cfg_wen && !busy) begin
        case (cfg_addr)
          2'd0:    src_q <= {cfg_wdata[17:2], 2'b00};
          2'd1:    dst_q <= {cfg_wdata[17:2], 2'b00};
          2'd2:    len_q <= cfg_wdata[15:0];
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      rd_left     <= '0;
      wr_left     <= '0;
      pipe        <= '0;
      fifo_rd_idx <= '0;
      fifo_wr_idx <= '0;
      fifo_cnt    <= '0;
    end else if (clk_en) begin
      if (abort) begin
        pipe        <= '0;
        fifo_rd_idx <= '0;
        fifo_wr_idx <= '0;
        fifo_cnt    <= '0;
      end else begin
        pipe <= pipe_nxt;
        if (launch) begin
          rd_ptr  <= src_q;
          wr_ptr  <= dst_q;
          rd_left <= len_q;
          wr_left <= len_q;
        end
        if (issue) begin
          rd_ptr  <= rd_ptr + 18'd4;
          rd_left <= rd_left - 16'd1;
        end
        if (eng_wr) begin
          wr_ptr      <= wr_ptr + 18'd4;
          wr_left     <= wr_left - 16'd1;
          fifo_rd_idx <= fifo_rd_idx + 1'b1;
        end
        if (push) fifo_wr_idx <= fifo_wr_idx + 1'b1;
        case ({push, eng_wr})
          2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
          2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) fifo_mem[i] <= '0;
    end else if (push) begin
      fifo_mem[fifo_wr_idx] <= mem_rdata1;
    end
  end

  always_comb begin
    mem_raddr1 = issue ? rd_ptr : cpu_raddr1;
    mem_wen    = '0;
    mem_waddr  = cpu_waddr;
    mem_wdata  = cpu_wdata;
    if (cpu_wen != '0) begin
      if (clk_en) mem_wen = cpu_wen;
    end else if (eng_wr) begin
      mem_wen   = '1;
      mem_waddr = wr_ptr;
      mem_wdata = fifo_mem[fifo_rd_idx];
    end
  end

  always_comb begin
    cfg_rdata = '0;
    case (cfg_addr)
      2'd0:    cfg_rdata = {14'd0, src_q};
      2'd1:    cfg_rdata = {14'd0, dst_q};
      2'd2:    cfg_rdata = {16'd0, len_q};
      default: cfg_rdata = {30'd0, done_q, busy};
    endcase
  end

endmodule

// File: tb/tb_mem_dma.sv
// Bench for mem_dma: behavioural RAM with RD_LAT read latency, monitor of engine traffic,
// directed scenarios plus randomized transfers checked against address/data rules.
module tb_mem_dma;
  localparam int RD_LAT     = 2;
  localparam int FIFO_DEPTH = 4;
  localparam logic [17:0] SENT = 18'h3FFF0;
  localparam int LIMIT = 400;

  logic        clk = 1'b0;
  logic        rst_n, clk_en, cfg_wen;
  logic [1:0]  cfg_addr;
  logic [31:0] cfg_wdata, cfg_rdata;
  logic [17:0] cpu_raddr1;
  logic        cpu_rreq1;
  logic [3:0]  cpu_wen;
  logic [17:0] cpu_waddr;
  logic [31:0] cpu_wdata;
  logic [17:0] mem_raddr1;
  logic [31:0] mem_rdata1;
  logic [3:0]  mem_wen;
  logic [17:0] mem_waddr;
  logic [31:0] mem_wdata;
  logic        busy, irq;

  always #5 clk = ~clk;

  mem_dma #(.RD_LAT(RD_LAT), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .clk_en(clk_en),
    .cfg_wen(cfg_wen), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata), .cfg_rdata(cfg_rdata),
    .cpu_raddr1(cpu_raddr1), .cpu_rreq1(cpu_rreq1),
    .cpu_wen(cpu_wen), .cpu_waddr(cpu_waddr), .cpu_wdata(cpu_wdata),
    .mem_raddr1(mem_raddr1), .mem_rdata1(mem_rdata1),
    .mem_wen(mem_wen), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
    .busy(busy), .irq(irq)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] pat(input logic [17:0] a);
    return {14'h2A5, a} ^ {a[17:2], 16'h0};
  endfunction

  function automatic logic [17:0] adv(input logic [17:0] a, input int n);
    return a + 18'(n * 4);
  endfunction

  // RAM: every word initially holds pat(address); reads return after RD_LAT clk_en edges.
  logic [31:0] mem [65536];
  logic [31:0] rd_s0 = '0, rd_s1 = '0;
  bit filled = 1'b0;
  assign mem_rdata1 = rd_s1;

  always @(posedge clk) begin
    if (!filled) begin
      for (int i = 0; i < 65536; i++) mem[i] = pat(18'(i * 4));
      filled = 1'b1;
    end
    if (clk_en) begin
      rd_s1 <= rd_s0;
      rd_s0 <= mem[mem_raddr1[17:2]];
    end
    for (int b = 0; b < 4; b++)
      if (mem_wen[b]) mem[mem_waddr[17:2]][8*b +: 8] = mem_wdata[8*b +: 8];
  end

  bit mon_on = 1'b0;
  int n_rd, n_wr, n_irq, n_busy, outstanding, max_out, rreq_viol;
  logic [17:0] exp_src, exp_dst;
  logic [17:0] rd_log [$];

  always @(negedge clk) if (mon_on) begin
    if (clk_en && !cpu_rreq1 && mem_raddr1 != cpu_raddr1) begin
      rd_log.push_back(mem_raddr1);
      n_rd++;
      outstanding++;
    end
    if (cpu_rreq1 && mem_raddr1 != cpu_raddr1) rreq_viol++;
    if (cpu_wen == 4'h0 && mem_wen != 4'h0) begin
      check("eng_wen", 32'(mem_wen), 32'hF);
      check("eng_waddr", 32'(mem_waddr), 32'(adv(exp_dst, n_wr)));
      check("eng_wdata", mem_wdata, pat(adv(exp_src, n_wr)));
      n_wr++;
      outstanding--;
    end
    if (outstanding > max_out) max_out = outstanding;
    if (irq && clk_en) n_irq++;
    if (busy) n_busy++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    clk_en = 1'b1; cfg_wen = 1'b0; cpu_rreq1 = 1'b0; cpu_raddr1 = SENT;
    cpu_wen = 4'h0; cpu_waddr = '0; cpu_wdata = '0;
  endtask

  task automatic cfg_write(input logic [1:0] a, input logic [31:0] d);
    clk_en = 1'b1; cfg_wen = 1'b1; cfg_addr = a; cfg_wdata = d;
    tick();
    cfg_wen = 1'b0;
  endtask

  task automatic cfg_read(input logic [1:0] a, output logic [31:0] d);
    cfg_addr = a;
    #1;
    d = cfg_rdata;
  endtask

  logic [31:0] last_cpu_data;

  // mode: 0 idle CPU, 1 rreq burst, 2 CPU writes, 3 abort after 3 writes, 4 cfg writes while busy, 5 random
  task automatic run_xfer(input logic [31:0] s_w, input logic [31:0] d_w, input logic [15:0] n,
                          input int mode, output int cycles);
    bit aborted;
    aborted = 1'b0;
    exp_src = {s_w[17:2], 2'b00};
    exp_dst = {d_w[17:2], 2'b00};
    n_rd = 0; n_wr = 0; n_irq = 0; n_busy = 0; outstanding = 0; max_out = 0; rreq_viol = 0;
    rd_log.delete();
    cfg_write(2'd0, s_w);
    cfg_write(2'd1, d_w);
    cfg_write(2'd2, 32'(n));
    mon_on = 1'b1;
    cfg_write(2'd3, 32'h1);
    cycles = 0;
    while (!irq && cycles < LIMIT) begin
      idle_inputs();
      if (cycles == 0 && n != 16'd0) begin
        cfg_addr = 2'd3;
        #1;
        check("ctrl_running", cfg_rdata, 32'h1);
      end
      case (mode)
        1: if (cycles >= 1 && cycles <= 5) begin cpu_rreq1 = 1'b1; cpu_raddr1 = 18'h00400; end
        2: if (cycles % 2 == 0) begin
             cpu_wen = 4'hF; cpu_waddr = 18'h00040; cpu_wdata = $urandom; last_cpu_data = cpu_wdata;
           end
        3: if (n_wr == 3 && !aborted) begin
             cfg_wen = 1'b1; cfg_addr = 2'd3; cfg_wdata = 32'h2; aborted = 1'b1;
           end
        4: if (cycles >= 1 && cycles <= 3) begin
             cfg_wen = 1'b1; cfg_addr = 2'(cycles - 1);
             cfg_wdata = (cycles == 3) ? 32'd5 : 32'h0000_0111 * 32'(cycles);
           end
        5: begin
             clk_en = ($urandom_range(0, 3) != 0);
             if ($urandom_range(0, 3) == 0) begin
               cpu_rreq1 = 1'b1; cpu_raddr1 = 18'($urandom) & 18'h3FFFC;
             end
             if ($urandom_range(0, 3) == 0) begin
               cpu_wen = 4'($urandom_range(1, 15)); cpu_waddr = 18'h00080; cpu_wdata = $urandom;
             end
           end
        default: ;
      endcase
      tick();
      cycles++;
    end
    check("xfer_irq_seen", 32'(irq), 32'h1);
    idle_inputs();
    tick();
    mon_on = 1'b0;
  endtask

  task automatic post(input logic [17:0] s, input logic [17:0] d, input int n_exp, input int rd_exp);
    logic [31:0] r;
    logic [17:0] da, sa;
    check("irq_count", 32'(n_irq), 32'd1);
    check("busy_end", 32'(busy), 32'd0);
    cfg_read(2'd3, r);
    check("ctrl_done", r, 32'h2);
    if (rd_exp >= 0) check("n_reads", 32'(n_rd), 32'(rd_exp));
    check("n_writes", 32'(n_wr), 32'(n_exp));
    for (int i = 0; i < n_exp; i++) begin
      da = adv(d, i);
      sa = adv(s, i);
      check("dst_word", mem[da[17:2]], pat(sa));
    end
  endtask

  initial begin
    int c0, c1;
    logic [31:0] r;
    logic [17:0] rs, rdst, wa;
    logic [15:0] rn;
    logic [17:0] exp_rd [3];

    idle_inputs();
    cfg_addr = 2'd0; cfg_wdata = '0; rst_n = 1'b0;
    repeat (3) tick();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_irq", 32'(irq), 32'd0);
    check("rst_mem_wen", 32'(mem_wen), 32'd0);
    for (int a = 0; a < 4; a++) begin
      cfg_read(2'(a), r);
      check("rst_cfg", r, 32'd0);
    end
    rst_n = 1'b1;
    tick();

    // Zero-length start: immediate completion, engine never busy
    run_xfer(32'h300, 32'h2E000, 16'd0, 0, c0);
    check("len0_cycles", 32'(c0), 32'd0);
    check("len0_busy", 32'(n_busy), 32'd0);
    post(18'h300, 18'h2E000, 0, 0);

    // Basic copy into tile_map region
    run_xfer(32'h100, 32'h2A000, 16'd4, 0, c0);
    post(18'h100, 18'h2A000, 4, 4);

    // CPU holds port 1 for 5 cycles after the first engine read
    run_xfer(32'h100, 32'h2A000, 16'd4, 1, c1);
    check("rreq_delay", 32'(c1), 32'(c0 + 5));
    check("rreq_no_issue", 32'(rreq_viol), 32'd0);
    post(18'h100, 18'h2A000, 4, 4);

    // CPU writes every other cycle; buffer occupancy stays within depth
    run_xfer(32'h200, 32'h2B000, 16'd8, 2, c1);
    post(18'h200, 18'h2B000, 8, 8);
    check("cpu_write_landed", mem[18'h00040 >> 2], last_cpu_data);
    check("max_outstanding", 32'(max_out <= FIFO_DEPTH), 32'd1);

    // Abort after the third destination write
    run_xfer(32'h400, 32'h2C000, 16'd16, 3, c1);
    post(18'h400, 18'h2C000, 3, -1);
    wa = 18'h2C00C;
    check("abort_4th_untouched", mem[wa[17:2]], pat(wa));

    // Source wraps past the top of the address space; config locked while busy
    run_xfer(32'hFFFF_FFFB, 32'h0002_D003, 16'd3, 4, c1);
    post(18'h3FFF8, 18'h2D000, 3, 3);
    exp_rd = '{18'h3FFF8, 18'h3FFFC, 18'h00000};
    check("wrap_read_count", 32'(rd_log.size()), 32'd3);
    for (int i = 0; i < 3 && i < rd_log.size(); i++) check("wrap_read_addr", 32'(rd_log[i]), 32'(exp_rd[i]));
    cfg_read(2'd0, r); check("src_locked", r, 32'h3FFF8);
    cfg_read(2'd1, r); check("dst_locked", r, 32'h2D000);
    cfg_read(2'd2, r); check("len_locked", r, 32'd3);

    // Reset mid-transfer: back to idle, no irq
    exp_src = 18'h500; exp_dst = 18'h2F000;
    n_rd = 0; n_wr = 0; n_irq = 0; outstanding = 0;
    cfg_write(2'd0, 32'h500);
    cfg_write(2'd1, 32'h2F000);
    cfg_write(2'd2, 32'd16);
    mon_on = 1'b1;
    cfg_write(2'd3, 32'h1);
    repeat (5) tick();
    rst_n = 1'b0;
    #1;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_irq", 32'(irq), 32'd0);
    cfg_read(2'd3, r); check("midrst_ctrl", r, 32'd0);
    cfg_read(2'd0, r); check("midrst_src", r, 32'd0);
    tick();
    rst_n = 1'b1;
    repeat (3) tick();
    mon_on = 1'b0;
    check("midrst_no_irq", 32'(n_irq), 32'd0);

    // Randomized transfers with clk_en gaps and CPU contention
    for (int k = 0; k < 4; k++) begin
      rs   = 18'h01000 + 18'($urandom_range(0, 16'h3000) * 4);
      rdst = 18'h30000 + 18'($urandom_range(0, 16'h3000) * 4);
      rn   = 16'($urandom_range(1, 20));
      run_xfer(32'(rs), 32'(rdst), rn, 5, c1);
      post(rs, rdst, int'(rn), int'(rn));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
